// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray-code counter family.
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [MAX_WIDTH-1:0] ZERO     = '0;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Binary to reflected Gray; callers truncate to their own width.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray to binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic run;

  always_comb begin
    bin = '0;
    run = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      run    = run ^ gray[i];
      bin[i] = run;
    end
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with parallel binary load and wrap or saturate at the limits.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LIM_HI = WIDTH'(ALL_ONES);
  localparam logic [WIDTH-1:0] LIM_LO = WIDTH'(ZERO);

  logic [WIDTH-1:0] bin_step;
  logic [WIDTH-1:0] gray_step;
  logic [WIDTH-1:0] gray_load;
  logic [WIDTH-1:0] gray_nxt;
  logic             at_limit;
  logic             tc_nxt;

  // Single decoder feeds both the binary view and the step arithmetic.
  gray_to_binary #(.WIDTH(WIDTH)) u_g2b (
    .gray (gray_out),
    .bin  (bin_out)
  );

  always_comb begin
    at_limit  = (up_dn == DIR_UP) ? (bin_out == LIM_HI) : (bin_out == LIM_LO);
    bin_step  = (up_dn == DIR_UP) ? (bin_out + WIDTH'(1)) : (bin_out - WIDTH'(1));
    gray_step = WIDTH'(bin2gray(MAX_WIDTH'(bin_step)));
    gray_load = WIDTH'(bin2gray(MAX_WIDTH'(load_bin)));
  end

  // Next state for load > count > hold; limit steps wrap or hold by WRAP.
  always_comb begin
    gray_nxt = gray_out;
    tc_nxt   = 1'b0;
    if (load) begin
      gray_nxt = gray_load;
    end else if (en) begin
      if (at_limit) begin
        tc_nxt = 1'b1;
        if (WRAP) begin
          gray_nxt = gray_step;
        end
      end else begin
        gray_nxt = gray_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_out <= '0;
      tc       <= 1'b0;
    end else begin
      gray_out <= gray_nxt;
      tc       <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three configurations against an integer-count reference model.
module tb_gray_counter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rsts [N];
  logic ens  [N];
  logic ups  [N];
  logic lds  [N];
  logic [3:0] lb0, lb1;
  logic [7:0] lb2;
  logic [3:0] g0, b0, g1, b1;
  logic [7:0] g2, b2;
  logic t0, t1, t2;

  int errors = 0;
  int checks = 0;

  int mb   [N];
  bit mtc  [N];
  bit mcnt [N];
  bit mval = 1'b0;
  int pg   [N];

  int gseq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_w4 (
    .clk(clk), .rst(rsts[0]), .en(ens[0]), .up_dn(ups[0]), .load(lds[0]),
    .load_bin(lb0), .gray_out(g0), .bin_out(b0), .tc(t0));

  gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_s4 (
    .clk(clk), .rst(rsts[1]), .en(ens[1]), .up_dn(ups[1]), .load(lds[1]),
    .load_bin(lb1), .gray_out(g1), .bin_out(b1), .tc(t1));

  gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_w8 (
    .clk(clk), .rst(rsts[2]), .en(ens[2]), .up_dn(ups[2]), .load(lds[2]),
    .load_bin(lb2), .gray_out(g2), .bin_out(b2), .tc(t2));

  function automatic int wid(input int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic bit wraps(input int i);
    return i != 1;
  endfunction

  function automatic int lbv(input int i);
    return (i == 0) ? int'(lb0) : (i == 1) ? int'(lb1) : int'(lb2);
  endfunction

  function automatic int gv(input int i);
    return (i == 0) ? int'(g0) : (i == 1) ? int'(g1) : int'(g2);
  endfunction

  function automatic int bv(input int i);
    return (i == 0) ? int'(b0) : (i == 1) ? int'(b1) : int'(b2);
  endfunction

  function automatic int tv(input int i);
    return (i == 0) ? int'(t0) : (i == 1) ? int'(t1) : int'(t2);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: plain integer count with limit rules.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int maxv;
      int prev;
      maxv = (1 << wid(i)) - 1;
      prev = mb[i];
      mcnt[i] = 1'b0;
      if (rsts[i]) begin
        mb[i] = 0; mtc[i] = 1'b0;
        if (i == 0) mval = 1'b1;
      end else if (lds[i]) begin
        mb[i] = lbv(i); mtc[i] = 1'b0;
      end else if (ens[i]) begin
        if (ups[i]) begin
          if (mb[i] == maxv) begin
            mtc[i] = 1'b1;
            if (wraps(i)) mb[i] = 0;
          end else begin
            mb[i] = mb[i] + 1; mtc[i] = 1'b0;
          end
        end else begin
          if (mb[i] == 0) begin
            mtc[i] = 1'b1;
            if (wraps(i)) mb[i] = maxv;
          end else begin
            mb[i] = mb[i] - 1; mtc[i] = 1'b0;
          end
        end
        mcnt[i] = (mb[i] != prev);
      end else begin
        mtc[i] = 1'b0;
      end
    end
  end

  // Every-cycle compare plus one-bit-change check on count edges.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mval) begin
        chk($sformatf("bin[%0d]", i), bv(i), mb[i]);
        chk($sformatf("gray[%0d]", i), gv(i), mb[i] ^ (mb[i] >> 1));
        chk($sformatf("tc[%0d]", i), tv(i), int'(mtc[i]));
        if (mcnt[i]) chk($sformatf("hamming[%0d]", i), $countones(gv(i) ^ pg[i]), 1);
      end
      pg[i] = gv(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rsts[i] = 1'b1; ens[i] = 1'b0; ups[i] = 1'b1; lds[i] = 1'b0;
    end
    lb0 = '0; lb1 = '0; lb2 = '0;
    tick();
    for (int i = 0; i < N; i++) rsts[i] = 1'b0;
    chk("reset_gray", int'(g0), 0);
    chk("reset_bin", int'(b0), 0);
    chk("reset_tc", int'(t0), 0);

    // Full up cycle with wrap
    ens[0] = 1'b1; ups[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t1_gray", int'(g0), gseq[(k + 1) % 16]);
      chk("t1_bin", int'(b0), (k + 1) % 16);
      chk("t1_tc", int'(t0), (k == 15) ? 1 : 0);
    end
    ens[0] = 1'b0;

    // Load zero then wrap downward
    lds[0] = 1'b1; lb0 = 4'd0;
    tick();
    lds[0] = 1'b0; ens[0] = 1'b1; ups[0] = 1'b0;
    tick();
    chk("t2_gray", int'(g0), 8);
    chk("t2_bin", int'(b0), 15);
    chk("t2_tc", int'(t0), 1);
    tick();
    chk("t2b_gray", int'(g0), 9);
    chk("t2b_bin", int'(b0), 14);
    chk("t2b_tc", int'(t0), 0);
    ens[0] = 1'b0;

    // Saturation at the top
    lds[1] = 1'b1; lb1 = 4'd14;
    tick();
    lds[1] = 1'b0; ens[1] = 1'b1; ups[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_bin", int'(b1), 15);
      chk("t3_tc", int'(t1), (k == 0) ? 0 : 1);
    end
    ups[1] = 1'b0;
    tick();
    chk("t3_back_bin", int'(b1), 14);
    chk("t3_back_tc", int'(t1), 0);
    ens[1] = 1'b0;

    // Priority: load beats count, reset beats load
    lds[0] = 1'b1; lb0 = 4'd9; ens[0] = 1'b1; ups[0] = 1'b1;
    tick();
    chk("t4_load_bin", int'(b0), 9);
    chk("t4_load_gray", int'(g0), 13);
    rsts[0] = 1'b1; lb0 = 4'd5;
    tick();
    chk("t4_rst_gray", int'(g0), 0);
    chk("t4_rst_bin", int'(b0), 0);
    rsts[0] = 1'b0; lds[0] = 1'b0;

    // Reset in the middle of counting, then freeze
    for (int k = 0; k < 6; k++) tick();
    chk("t5_pre_bin", int'(b0), 6);
    rsts[0] = 1'b1;
    tick();
    chk("t5_rst_gray", int'(g0), 0);
    chk("t5_rst_tc", int'(t0), 0);
    rsts[0] = 1'b0;
    tick();
    chk("t5_resume1", int'(b0), 1);
    tick();
    chk("t5_resume2", int'(b0), 2);
    ens[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_hold_bin", int'(b0), 2);
      chk("t5_hold_tc", int'(t0), 0);
    end

    // 8-bit wrap
    lds[2] = 1'b1; lb2 = 8'd254;
    tick();
    lds[2] = 1'b0; ens[2] = 1'b1; ups[2] = 1'b1;
    tick();
    chk("t6_bin255", int'(b2), 255);
    chk("t6_gray255", int'(g2), 128);
    chk("t6_tc255", int'(t2), 0);
    tick();
    chk("t6_bin0", int'(b2), 0);
    chk("t6_gray0", int'(g2), 0);
    chk("t6_tc0", int'(t2), 1);
    tick();
    chk("t6_bin1", int'(b2), 1);
    chk("t6_gray1", int'(g2), 1);
    chk("t6_tc1", int'(t2), 0);

    // Randomized traffic on all three instances
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++) begin
        rsts[i] = ($urandom_range(0, 63) == 0);
        lds[i]  = ($urandom_range(0, 15) == 0);
        ens[i]  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) ups[i] = ~ups[i];
      end
      lb0 = 4'($urandom);
      lb1 = 4'($urandom);
      lb2 = 8'($urandom);
      tick();
    end

    for (int i = 0; i < N; i++) begin
      rsts[i] = 1'b0; ens[i] = 1'b0; lds[i] = 1'b0;
    end
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised synchronous Gray-code counter. It is the sequential successor to the lab's fixed 4-bit binary-to-Gray converter.
- State is held in Gray form. Each step changes exactly one output bit.
- A binary view is decoded from the state. Supports up/down counting, parallel load of a binary value, and wrap or saturate mode.
- Used by later labs for pointer and position encoding.

Parameters:
- WIDTH, 4, counter width in bits (min 2).
- WRAP, 1, 1 = wrap at the count limits; 0 = saturate at the count limits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per clk when high.
- up_dn  input  1  1 = count up, 0 = count down; sampled only when en=1.
- load  input  1  parallel load strobe.
- load_bin  input  WIDTH  binary value to load; converted to Gray internally.
- gray_out  output  WIDTH  registered Gray state.
- bin_out  output  WIDTH  binary decode of gray_out, combinational from the state register.
- tc  output  1  registered terminal-count / limit-event flag.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset: on a clk edge with rst=1, gray_out=0, bin_out=0, tc=0. Reset overrides load and en, including in the middle of a count.
- Priority at each clk edge: rst > load > en > hold.
- Load:
  - gray_out <= load_bin ^ (load_bin >> 1).
  - bin_out equals load_bin in the cycle after the edge.
  - tc <= 0.
  - Latency is 1 clk.
- Count (en=1, load=0):
  - b = gray_to_bin(gray_out).
  - Up: nb = b+1. Down: nb = b-1. Arithmetic is WIDTH-bit modulo.
  - gray_out <= nb ^ (nb >> 1).
- Limits:
  - Up limit: b = 2^WIDTH-1.
  - Down limit: b = 0.
- WRAP=1:
  - At a limit, the counter wraps: all-ones goes to 0, and 0 goes to all-ones.
  - tc <= 1 for exactly the one cycle following the wrap edge; otherwise tc <= 0.
- WRAP=0:
  - At a limit, the state holds (no change).
  - tc <= 1 on every enabled edge that attempts to step past the limit. Continuous pushing keeps tc high.
  - A step in the opposite direction clears tc on that edge.
- Hold (en=0, load=0): state unchanged, tc <= 0.
- Invariant: between any two consecutive enabled count edges, gray_out differs in exactly one bit. This includes the wrap edge in WRAP=1 (all-ones Gray = 100..0 goes to 000..0).
- A direction change takes effect on the same edge it is sampled. There is no pipeline.
- All outputs are defined from the first post-reset edge. Before the first reset, outputs are X.

Decomposition:
- Shared package/header gray_pkg:
  - Function bin2gray(WIDTH).
  - Localparams for limit values (ALL_ONES, ZERO).
  - Direction constants DIR_UP=1, DIR_DN=0.
- Sub-module gray_to_binary:
  - Parametrised WIDTH, purely combinational.
  - b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - Instantiated once; it drives both bin_out and next-state arithmetic.
- Top module contains:
  - State register.
  - Next-state mux for the rst/load/en priority.
  - Limit detect.
  - tc register.

Test Plan:
1. WIDTH=4, WRAP=1: rst 1 cycle, then en=1 up_dn=1 for 16 clk.
   - gray_out goes 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
   - bin_out = 0..15 then 0.
   - tc=1 only in the cycle after 1000→0000.
   - Every transition has a Hamming distance of 1.
2. WIDTH=4, WRAP=1: load load_bin=4'd0 then count down 1 step.
   - gray_out=1000, bin_out=15, tc=1 for one cycle.
   - Next down step: gray_out=1001, bin_out=14, tc=0.
3. WIDTH=4, WRAP=0: load 4'd14, then en=1 up_dn=1 for 3 clk.
   - bin_out sequence: 15, 15, 15.
   - tc sequence: 0, 1, 1.
   - Then up_dn=0 for 1 clk: bin_out=14, tc=0.
4. Priority:
   - load=1 with load_bin=4'd9, en=1, up_dn=1 on the same edge: bin_out=9 (not 10), gray_out=1101.
   - rst=1 with load=1 on the same edge: gray_out=0000, bin_out=0.
5. Reset mid-operation:
   - Count up to bin_out=6, assert rst for 1 clk while en=1: gray_out=0, tc=0.
   - Release rst: count resumes 1, 2, ….
   - en=0 for 5 clk: state frozen, tc=0.
6. WIDTH=8, WRAP=1: load 8'd254, count up 3 steps.
   - bin_out sequence: 255, 0, 1.
   - gray_out: 10000000 → 00000000 → 00000001.
   - tc=1 only after the 255→0 edge.
   - Random up/down stimulus, 1000 cycles: a scoreboard checks bin_out against a reference model and checks the one-bit-change invariant.
